// File: rtl/prog_logic_function_if.sv
// Bus bundle for prog_logic_function: evaluation and table-load ports.
// PLF_READBACK_EN adds the rd_* table readback signals.
interface prog_logic_function_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  logic [N_IN-1:0]  x;
  logic             x_valid;
  logic [N_OUT-1:0] y;
  logic [N_OUT-1:0] yinv;
  logic             y_valid;
  logic             cfg_start;
  logic [N_OUT-1:0] cfg_data;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_done;
  logic             programmed;
`ifdef PLF_READBACK_EN
  logic             rd_en;
  logic [N_IN-1:0]  rd_addr;
  logic [N_OUT-1:0] rd_data;
  logic             rd_valid;
`endif

  modport master (
    output x, x_valid,
    output cfg_start, cfg_data, cfg_valid,
`ifdef PLF_READBACK_EN
    output rd_en, rd_addr,
    input  rd_data, rd_valid,
`endif
    input  y, yinv, y_valid,
    input  cfg_ready, cfg_done, programmed
  );

  modport slave (
    input  x, x_valid,
    input  cfg_start, cfg_data, cfg_valid,
`ifdef PLF_READBACK_EN
    input  rd_en, rd_addr,
    output rd_data, rd_valid,
`endif
    output y, yinv, y_valid,
    output cfg_ready, cfg_done, programmed
  );
endinterface

// File: rtl/prog_logic_function.sv
// Registered programmable truth table, loaded row by row over cfg port.
// PLF_READBACK_EN adds a registered table readback port.
module prog_logic_function #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  prog_logic_function_if.slave bus
);

  localparam int DEPTH = 1 << N_IN;
  localparam int CW    = N_IN + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             cfg_done_q;
  logic [N_OUT-1:0] tbl [DEPTH];
  logic [N_OUT-1:0] y_q;
  logic             y_valid_q;
  logic             ready;
  logic             beat;
  logic             last;
  logic             eval;

  assign ready = (state == LOAD) & ~bus.cfg_start;
  assign beat  = ready & bus.cfg_valid;
  assign last  = cnt == CW'(DEPTH - 1);
  assign eval  = (state == RUN) & bus.x_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cfg_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (bus.cfg_start) begin
          cnt_nxt = '0;
        end else if (beat) begin
          cnt_nxt = cnt + 1'b1;
          if (last) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.cfg_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cfg_done_q <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (beat) begin
      tbl[cnt[N_IN-1:0]] <= bus.cfg_data;
    end
  end

  // Evaluation reads the table before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= eval;
      if (eval) begin
        y_q <= tbl[bus.x];
      end
    end
  end

  assign bus.y          = y_q;
  assign bus.yinv       = ~y_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.cfg_ready  = ready;
  assign bus.cfg_done   = cfg_done_q;
  assign bus.programmed = state == RUN;

`ifdef PLF_READBACK_EN
  logic [N_OUT-1:0] rd_data_q;
  logic             rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= tbl[bus.rd_addr];
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_prog_logic_function.sv
// Randomized bench for prog_logic_function with an in-bench table model.
// Readback checks are built only with PLF_READBACK_EN.
module tb_prog_logic_function;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int DEPTH = 16;

  localparam int M_EMPTY   = 0;
  localparam int M_LOADING = 1;
  localparam int M_READY   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  prog_logic_function_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  prog_logic_function #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit cmp_on = 1'b0;

  int         m_mode = M_EMPTY;
  int         m_row = 0;
  logic [2:0] mtab [DEPTH];
  logic [2:0] m_y = '0;
  bit         m_yv = 1'b0;
  bit         m_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a table that fills in order, and lookups only once full.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_EMPTY;
      m_row  <= 0;
      m_y    <= '0;
      m_yv   <= 1'b0;
      m_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mtab[i] <= '0;
    end else begin
      m_yv   <= (m_mode == M_READY) && bus.x_valid;
      m_done <= 1'b0;
      if (m_mode == M_READY && bus.x_valid) m_y <= mtab[bus.x];
      if (bus.cfg_start) begin
        m_mode <= M_LOADING;
        m_row  <= 0;
      end else if (m_mode == M_LOADING && bus.cfg_valid) begin
        mtab[m_row] <= bus.cfg_data;
        m_row <= m_row + 1;
        if (m_row == DEPTH - 1) begin
          m_mode <= M_READY;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [2:0] ny;
    #1;
    if (cmp_on) begin
      ny = ~m_y;
      check("y", bus.y, m_y);
      check("yinv", bus.yinv, ny);
      check("y_valid", bus.y_valid, m_yv);
      check("cfg_ready", bus.cfg_ready,
            m_mode == M_LOADING && !bus.cfg_start);
      check("cfg_done", bus.cfg_done, m_done);
      check("programmed", bus.programmed, m_mode == M_READY);
      if (bus.cfg_done) done_cnt++;
    end
  end

  function automatic logic [2:0] row_val(input int kind, input int i);
    logic [2:0] t;
    t = i[2:0];
    case (kind)
      0: return t;
      1: return ~t;
      default: return 3'($urandom);
    endcase
  endfunction

  task automatic load_rows(input int kind);
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.cfg_data = row_val(kind, i);
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic eval_all();
    bus.x_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.x = 4'(i);
      @(negedge clk);
    end
    bus.x_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int d0;
    bus.x = '0;
    bus.x_valid = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_data = '0;
    bus.cfg_valid = 1'b0;
`ifdef PLF_READBACK_EN
    bus.rd_en = 1'b0;
    bus.rd_addr = '0;
`endif
    #1 rst_n = 1'b0;
    #2 cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    bus.x = 4'h5;
    bus.x_valid = 1'b1;
    @(negedge clk);
    check("idle_y_valid", bus.y_valid, 0);
    check("idle_y", bus.y, 3'b000);
    check("idle_yinv", bus.yinv, 3'b111);
    check("idle_programmed", bus.programmed, 0);
    check("idle_cfg_ready", bus.cfg_ready, 0);
    bus.x_valid = 1'b0;

    d0 = done_cnt;
    load_rows(0);
    check("load_done", bus.cfg_done, 1);
    check("load_programmed", bus.programmed, 1);
    bus.x = 4'hB;
    bus.x_valid = 1'b1;
    @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("done_drop", bus.cfg_done, 0);
    check("eval_b_y", bus.y, 3'b011);
    check("eval_b_yinv", bus.yinv, 3'b100);
    check("eval_b_valid", bus.y_valid, 1);

    for (int i = 0; i < DEPTH; i++) begin
      bus.x = 4'(i);
      @(negedge clk);
      check("sweep_y", bus.y, i % 8);
      check("sweep_valid", bus.y_valid, 1);
    end

    bus.x = 4'h7;
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    bus.x_valid = 1'b0;
    #1;
    check("race_y", bus.y, 3'b111);
    check("race_valid", bus.y_valid, 1);
    check("race_programmed", bus.programmed, 0);
    check("race_ready", bus.cfg_ready, 1);

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data = 3'($urandom);
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 6; i < 10; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data = 3'($urandom);
      @(negedge clk);
    end
    bus.cfg_start = 1'b1;
    bus.cfg_data = 3'b111;
    #1;
    check("restart_ready", bus.cfg_ready, 0);
    @(negedge clk);
    bus.cfg_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.cfg_data = 3'($urandom);
      @(negedge clk);
      check("restart_done", bus.cfg_done, i == DEPTH - 1);
    end
    bus.cfg_valid = 1'b0;
    check("restart_programmed", bus.programmed, 1);
    eval_all();

    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cfg_data = 3'($urandom);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_y", bus.y, 3'b000);
    check("rst_yinv", bus.yinv, 3'b111);
    check("rst_y_valid", bus.y_valid, 0);
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_cfg_done", bus.cfg_done, 0);
    check("rst_programmed", bus.programmed, 0);
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_rows(2);
    eval_all();

    repeat (1500) begin
      bus.x = 4'($urandom);
      bus.x_valid = 1'($urandom % 2);
      bus.cfg_valid = ($urandom % 10) < 7;
      bus.cfg_data = 3'($urandom);
      bus.cfg_start = ($urandom % 40) == 0;
      @(negedge clk);
    end
    bus.x_valid = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_start = 1'b0;
    @(negedge clk);

`ifdef PLF_READBACK_EN
    load_rows(1);
    bus.rd_en = 1'b1;
    bus.rd_addr = 4'h2;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("rd_data", bus.rd_data, 3'b101);
    check("rd_valid", bus.rd_valid, 1);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_logic_function.md
# prog_logic_function

Programmable, registered successor to the fixed four-input logic-function blocks. The N_IN-input, N_OUT-output truth table lives in registers and is loaded row by row over a valid/ready configuration port. The block registers the addressed row, together with its bitwise complement, one cycle after each valid input vector. It sits in the lab datapath wherever a combinational function was previously hard-coded, so the function can be changed without resynthesis.

## Interface
- N_IN, 4, number of function inputs; table depth is 2^N_IN rows (legal 1..8)
- N_OUT, 3, number of function outputs; row width (legal 1..16)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- x  in  N_IN  input vector (table address)
- x_valid  in  1  evaluate x this cycle
- y  out  N_OUT  registered function result
- yinv  out  N_OUT  always ~y
- y_valid  out  1  one-cycle pulse, y/yinv updated this cycle
- cfg_start  in  1  pulse; begin (re)load of the table from row 0
- cfg_data  in  N_OUT  truth-table row
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  block accepts a row this cycle
- cfg_done  out  1  one-cycle pulse after the last row is accepted
- programmed  out  1  table is complete and evaluation is enabled

## Operation
- Storage: 2^N_IN × N_OUT register array with row counter `cnt` of width N_IN+1.
- States: IDLE (unprogrammed), LOAD, RUN.
- IDLE:
  - cfg_start → LOAD, cnt=0.
  - x_valid is ignored.
- LOAD:
  - cfg_ready = ~cfg_start.
  - On a beat (cfg_valid & cfg_ready): table[cnt] ← cfg_data, cnt++.
  - The beat with cnt = 2^N_IN−1 moves to RUN and pulses cfg_done.
  - cfg_start while in LOAD restarts the load at cnt=0. Rows already written stay in the table until overwritten. No beat is accepted in that cycle.
  - x_valid is ignored: y holds and y_valid=0.
- RUN:
  - x_valid → y ← table[x], y_valid=1.
  - cfg_start → LOAD, cnt=0, programmed=0.
- Simultaneous x_valid and cfg_start in RUN: the evaluation completes using the old table (y_valid=1), and the state moves to LOAD.
- y holds its last value between evaluations.
- yinv = ~y at all times, driven from the same register with no added cycle.
- programmed = (state == RUN).
- Reset (asynchronous, any state, including mid-load):
  - state=IDLE, cnt=0, table all zeros.
  - y=0, yinv=all ones, y_valid=0, cfg_ready=0, cfg_done=0, programmed=0.
  - A partial load is discarded; a new cfg_start is required.

## Timing
- Evaluation latency: 1 cycle (x sampled at edge k; y, yinv and y_valid are visible after edge k).
- Full throughput: one evaluation per cycle while in RUN.
- Load:
  - First beat is possible in the cycle after cfg_start.
  - With cfg_valid held high, a full load takes 2^N_IN cycles after cfg_start.
  - cfg_done is asserted in the cycle after the final beat edge; programmed rises in the same cycle.
- Evaluation of x can start in the first cycle after the final row is accepted, and uses the new table.
- A stalled cfg_valid inserts idle cycles. There is no timeout.
- cfg_ready, cfg_done, y_valid and programmed are all registered or decoded from registered state. There is no combinational path from any input to these outputs, except cfg_start → cfg_ready.

## Configuration
- PLF_READBACK_EN:
  - Defined: adds ports rd_en (in, 1), rd_addr (in, N_IN), rd_data (out, N_OUT) and rd_valid (out, 1). rd_data ← table[rd_addr] one cycle after rd_en, in any state; reset value 0. Readback in the cycle a row is being written returns the old contents.
  - Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then x_valid=1, x=4'h5 → y_valid stays 0, y=3'b000, yinv=3'b111, programmed=0, cfg_ready=0.
- cfg_start, then 16 back-to-back beats with row i = i mod 8 → cfg_done pulses exactly once, in the cycle after beat 15, and programmed=1. Then x=4'hB → one cycle later y=3'b011, yinv=3'b100, y_valid=1.
- In RUN, drive x=0..15 on consecutive cycles → y_valid high for 16 consecutive cycles, with y matching each row one cycle late. Then x_valid and cfg_start together with x=4'h7 → y=3'b111 and state=LOAD.
- During a load, deassert cfg_valid for 3 cycles after row 5 and assert cfg_start after row 9 → cnt returns to 0, no beat accepted in the cfg_start cycle, and the load then needs a further 16 beats.
- Assert rst_n=0 asynchronously mid-load after row 7 → all outputs return to reset values immediately. Evaluation after a subsequent cfg_start plus a full load returns only the new rows.
- PLF_READBACK_EN defined: after loading row i = ~i[2:0], rd_en with rd_addr=4'h2 → rd_data=3'b101 one cycle later.
